// File: rtl/spi_boot_loader.sv
// Boot copier: streams NUM_WORDS big-endian 16-bit words from an SPI EEPROM (READ 0x03 @ 0x0000, mode 0) into SRAM.
// Optional feature macro SPI_BOOT_CHECKSUM_EN: sum written words and flag a non-zero total on o_bootErr.
module spi_boot_loader #(
  parameter int NUM_WORDS   = 32768,
  parameter int HALF_PERIOD = 1
) (
  input  logic        i_sysClk,
  input  logic        i_sysRstn,
  input  logic        i_spiMISO,
  output logic        o_spiMOSI,
  output logic        o_spiCLK,
  output logic        o_spiCSn,
  output logic [15:0] o_memAddr,
  output logic [15:0] o_memData,
  output logic        o_memWr,
  output logic        o_memEn,
  output logic        o_busy,
  output logic        o_booted,
  output logic        o_bootErr
);

  localparam int               DIV_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
  localparam logic [15:0]      LAST_IDX = 16'(NUM_WORDS - 1);
  localparam logic [23:0]      FRAME    = {8'h03, 16'h0000};

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CMD, S_ADDR, S_DATA, S_WRITE, S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_bit;
  logic [22:0]      r_tx;
  logic [15:0]      r_shift, r_idx, r_memAddr, r_memData;
  logic             r_sck, r_mosi, r_csn, r_memEn, r_memWr, r_busy, r_booted;
  logic             w_tick, w_shifting, w_fall, w_last_bit, w_idle_next;

  assign w_tick      = (r_div == DIV_LAST);
  assign w_shifting  = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_fall      = w_shifting && w_tick && r_sck;
  assign w_last_bit  = (r_state == S_CMD) ? (r_bit == 4'd7) : (r_bit == 4'd15);
  assign w_idle_next = (w_next == S_IDLE) || (w_next == S_DONE);

  // State register.
  always_ff @(posedge i_sysClk or negedge i_sysRstn) begin
    if (!i_sysRstn) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next state: shift phases advance on the SCK fall that ends their last bit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_SELECT;
      S_SELECT: if (w_tick) w_next = S_CMD; else w_next = S_SELECT;
      S_CMD:    if (w_fall && w_last_bit) w_next = S_ADDR; else w_next = S_CMD;
      S_ADDR:   if (w_fall && w_last_bit) w_next = S_DATA; else w_next = S_ADDR;
      S_DATA:   if (w_fall && w_last_bit) w_next = S_WRITE; else w_next = S_DATA;
      S_WRITE:  if (r_idx == LAST_IDX) w_next = S_DONE; else w_next = S_DATA;
      S_DONE:   w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  // SPI sequencing and SRAM port; SELECT doubles as the low phase before the first rise.
  always_ff @(posedge i_sysClk or negedge i_sysRstn) begin
    if (!i_sysRstn) begin
      r_div     <= '0;
      r_bit     <= 4'd0;
      r_tx      <= 23'd0;
      r_shift   <= 16'h0000;
      r_idx     <= 16'h0000;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_csn     <= 1'b1;
      r_memEn   <= 1'b0;
      r_memWr   <= 1'b0;
      r_memAddr <= 16'h0000;
      r_memData <= 16'h0000;
      r_busy    <= 1'b0;
      r_booted  <= 1'b0;
    end else begin
      if ((w_shifting || (r_state == S_SELECT)) && !w_tick) r_div <= r_div + 1'b1;
      else                                                  r_div <= '0;

      if ((r_state == S_SELECT) && w_tick) r_sck <= 1'b1;
      else if (w_shifting && w_tick)       r_sck <= ~r_sck;
      else if (!w_shifting)                r_sck <= 1'b0;

      if (w_fall)           r_bit <= w_last_bit ? 4'd0 : r_bit + 4'd1;
      else if (!w_shifting) r_bit <= 4'd0;

      if (r_state == S_IDLE) begin
        r_tx   <= FRAME[22:0];
        r_mosi <= FRAME[23];
      end else if (w_fall && (r_state != S_DATA)) begin
        r_tx   <= {r_tx[21:0], 1'b0};
        r_mosi <= r_tx[22];
      end

      if ((r_state == S_DATA) && w_tick && !r_sck) r_shift <= {r_shift[14:0], i_spiMISO};

      if ((r_state == S_WRITE) && (w_next == S_DATA)) r_idx <= r_idx + 16'd1;

      r_memEn <= (w_next == S_WRITE);
      r_memWr <= (w_next == S_WRITE);
      if (w_next == S_WRITE) begin
        r_memAddr <= r_idx;
        r_memData <= r_shift;
      end

      r_csn    <= w_idle_next;
      r_busy   <= !w_idle_next;
      r_booted <= (w_next == S_DONE);
    end
  end

  assign o_spiMOSI = r_mosi;
  assign o_spiCLK  = r_sck;
  assign o_spiCSn  = r_csn;
  assign o_memAddr = r_memAddr;
  assign o_memData = r_memData;
  assign o_memWr   = r_memWr;
  assign o_memEn   = r_memEn;
  assign o_busy    = r_busy;
  assign o_booted  = r_booted;

`ifdef SPI_BOOT_CHECKSUM_EN
  logic [15:0] r_sum, w_sum_next;
  logic        r_bootErr;

  assign w_sum_next = r_sum + r_memData;

  // Accumulate each word while it is on the SRAM bus; judge the total on the final write.
  always_ff @(posedge i_sysClk or negedge i_sysRstn) begin
    if (!i_sysRstn) begin
      r_sum     <= 16'h0000;
      r_bootErr <= 1'b0;
    end else if (r_state == S_WRITE) begin
      r_sum <= w_sum_next;
      if (w_next == S_DONE) r_bootErr <= (w_sum_next != 16'h0000);
    end
  end

  assign o_bootErr = r_bootErr;
`else
  assign o_bootErr = 1'b0;
`endif

endmodule

// File: tb/tb_spi_boot_loader.sv
// Bench: two loader instances (HALF_PERIOD 1 and 3) booting random images from a behavioural EEPROM model.
// Expected o_bootErr follows SPI_BOOT_CHECKSUM_EN when the bench is compiled with it.
module tb_spi_boot_loader;
  localparam int NA = 4, HA = 1, NB = 2, HB = 3;
`ifdef SPI_BOOT_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  logic rst_a, mosi_a, sck_a, csn_a, wr_a, en_a, busy_a, booted_a, err_a;
  logic rst_b, mosi_b, sck_b, csn_b, wr_b, en_b, busy_b, booted_b, err_b;
  logic miso_a = 1'b0, miso_b = 1'b0;
  logic [15:0] addr_a, data_a, addr_b, data_b;

  spi_boot_loader #(.NUM_WORDS(NA), .HALF_PERIOD(HA)) dut_a (
    .i_sysClk(clk), .i_sysRstn(rst_a), .i_spiMISO(miso_a), .o_spiMOSI(mosi_a),
    .o_spiCLK(sck_a), .o_spiCSn(csn_a), .o_memAddr(addr_a), .o_memData(data_a),
    .o_memWr(wr_a), .o_memEn(en_a), .o_busy(busy_a), .o_booted(booted_a), .o_bootErr(err_a));

  spi_boot_loader #(.NUM_WORDS(NB), .HALF_PERIOD(HB)) dut_b (
    .i_sysClk(clk), .i_sysRstn(rst_b), .i_spiMISO(miso_b), .o_spiMOSI(mosi_b),
    .o_spiCLK(sck_b), .o_spiCSn(csn_b), .o_memAddr(addr_b), .o_memData(data_b),
    .o_memWr(wr_b), .o_memEn(en_b), .o_busy(busy_b), .o_booted(booted_b), .o_bootErr(err_b));

  // EEPROM models: count SCK rises per CS frame, capture the 24 framing bits, shift data out on falls.
  logic [7:0]  img_a [2*NA];
  logic [7:0]  img_b [2*NB];
  logic [23:0] cmd_a = 24'h0, cmd_b = 24'h0;
  int cnt_a = 0, cnt_b = 0;

  always @(negedge csn_a) begin cnt_a = 0; cmd_a = 24'h0; end
  always @(posedge sck_a) if (!csn_a) begin
    if (cnt_a < 24) cmd_a = {cmd_a[22:0], mosi_a};
    cnt_a++;
  end
  always @(negedge sck_a) if (!csn_a && cnt_a >= 24) begin
    logic [7:0] bt;
    bt = img_a[((cnt_a - 24) / 8) % (2*NA)];
    miso_a = bt[7 - ((cnt_a - 24) % 8)];
  end

  always @(negedge csn_b) begin cnt_b = 0; cmd_b = 24'h0; end
  always @(posedge sck_b) if (!csn_b) begin
    if (cnt_b < 24) cmd_b = {cmd_b[22:0], mosi_b};
    cnt_b++;
  end
  always @(negedge sck_b) if (!csn_b && cnt_b >= 24) begin
    logic [7:0] bt;
    bt = img_b[((cnt_b - 24) / 8) % (2*NB)];
    miso_b = bt[7 - ((cnt_b - 24) % 8)];
  end

  // SRAM-side monitors: log writes, count protocol breaches and SCK phase lengths.
  logic [31:0] wq_a[$], wq_b[$];
  int bad_a = 0, mbad_a = 0, bad_b = 0, mbad_b = 0;
  int hi_cnt_b = 0, hi_bad_b = 0, lo3_b = 0, lo4_b = 0, lo_oth_b = 0, first_lo_b = -1, run_b = 0;
  logic pwr_a = 1'b0, pmosi_a = 1'b0, pwr_b = 1'b0, pmosi_b = 1'b0, pcsn_b = 1'b1, psck_b = 1'b0;

  always @(negedge clk) begin
    if (wr_a) wq_a.push_back({addr_a, data_a});
    if ((wr_a && (!en_a || pwr_a || sck_a || csn_a)) || (en_a && !wr_a)) bad_a++;
    if (!csn_a && sck_a && (mosi_a !== pmosi_a)) mbad_a++;
    pwr_a = wr_a; pmosi_a = mosi_a;

    if (wr_b) wq_b.push_back({addr_b, data_b});
    if ((wr_b && (!en_b || pwr_b || sck_b || csn_b)) || (en_b && !wr_b)) bad_b++;
    if (!csn_b && sck_b && (mosi_b !== pmosi_b)) mbad_b++;
    if (!csn_b) begin
      if (!pcsn_b && (sck_b == psck_b)) run_b++;
      else begin
        if (!pcsn_b && psck_b) begin
          hi_cnt_b++;
          if (run_b != HB) hi_bad_b++;
        end else if (!pcsn_b) begin
          if (first_lo_b < 0) first_lo_b = run_b;
          if (run_b == HB) lo3_b++;
          else if (run_b == HB + 1) lo4_b++;
          else lo_oth_b++;
        end
        run_b = 1;
      end
    end
    pwr_b = wr_b; pmosi_b = mosi_b; pcsn_b = csn_b; psck_b = sck_b;
  end

  task automatic boot_a(output bit ok);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    wq_a.delete(); bad_a = 0; mbad_a = 0;
    rst_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin @(negedge clk); ok = booted_a; end
  endtask

  task automatic boot_b(output bit ok);
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    wq_b.delete(); bad_b = 0; mbad_b = 0;
    hi_cnt_b = 0; hi_bad_b = 0; lo3_b = 0; lo4_b = 0; lo_oth_b = 0; first_lo_b = -1;
    rst_b = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin @(negedge clk); ok = booted_b; end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if ({csn_a, sck_a, mosi_a, en_a, wr_a, busy_a, booted_a, err_a} !== 8'b1000_0000) begin
      n_bad++; $display("FAIL reset_ctl_a: got %b want 10000000", {csn_a, sck_a, mosi_a, en_a, wr_a, busy_a, booted_a, err_a}); end
    n_cmp++; if ({addr_a, data_a} !== 32'h0) begin
      n_bad++; $display("FAIL reset_mem_a: got %h want 00000000", {addr_a, data_a}); end
    n_cmp++; if ({csn_b, sck_b, mosi_b, en_b, wr_b, busy_b, booted_b, err_b} !== 8'b1000_0000) begin
      n_bad++; $display("FAIL reset_ctl_b: got %b want 10000000", {csn_b, sck_b, mosi_b, en_b, wr_b, busy_b, booted_b, err_b}); end
  endtask

  // mode 0: random bytes, 1: all 0xFF, 2: all 0x00.
  task automatic test_framing(input int mode);
    bit ok;
    logic [31:0] exp;
    logic [15:0] sum = 16'h0;
    for (int i = 0; i < 2*NA; i++) img_a[i] = (mode == 0) ? 8'($urandom) : ((mode == 1) ? 8'hFF : 8'h00);
    for (int i = 0; i < NA; i++) sum = sum + {img_a[2*i], img_a[2*i+1]};
    boot_a(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL framing_timeout[%0d]: booted never rose", mode); end
    n_cmp++; if (cmd_a !== 24'h030000) begin n_bad++; $display("FAIL framing_cmd[%0d]: got %h want 030000", mode, cmd_a); end
    n_cmp++; if (cnt_a !== 24 + 16*NA) begin n_bad++; $display("FAIL framing_rises[%0d]: got %0d want %0d", mode, cnt_a, 24 + 16*NA); end
    n_cmp++; if (wq_a.size() !== NA) begin n_bad++; $display("FAIL framing_nwrites[%0d]: got %0d want %0d", mode, wq_a.size(), NA); end
    for (int i = 0; i < NA && i < wq_a.size(); i++) begin
      exp = {16'(i), img_a[2*i], img_a[2*i+1]};
      n_cmp++; if (wq_a[i] !== exp) begin n_bad++; $display("FAIL framing_write[%0d.%0d]: got %h want %h", mode, i, wq_a[i], exp); end
    end
    n_cmp++; if ({bad_a, mbad_a} !== 64'h0) begin n_bad++; $display("FAIL framing_protocol[%0d]: strobe errs %0d mosi errs %0d want 0", mode, bad_a, mbad_a); end
    n_cmp++; if ({csn_a, sck_a, busy_a, booted_a, en_a, wr_a} !== 6'b100100) begin
      n_bad++; $display("FAIL framing_done[%0d]: got %b want 100100", mode, {csn_a, sck_a, busy_a, booted_a, en_a, wr_a}); end
    n_cmp++; if (addr_a !== 16'(NA - 1)) begin n_bad++; $display("FAIL framing_lastaddr[%0d]: got %h want %h", mode, addr_a, 16'(NA - 1)); end
    n_cmp++; if (err_a !== (CK_EN && (sum != 16'h0))) begin n_bad++; $display("FAIL framing_err[%0d]: got %b want %b", mode, err_a, CK_EN && (sum != 16'h0)); end
  endtask

  task automatic test_divider();
    bit ok;
    img_b = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    boot_b(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL div_timeout: booted never rose"); end
    n_cmp++; if (cmd_b !== 24'h030000) begin n_bad++; $display("FAIL div_cmd: got %h want 030000", cmd_b); end
    n_cmp++; if (wq_b.size() !== 2) begin n_bad++; $display("FAIL div_nwrites: got %0d want 2", wq_b.size()); end
    else begin
      n_cmp++; if (wq_b[0] !== 32'h0000_1234) begin n_bad++; $display("FAIL div_write0: got %h want 00001234", wq_b[0]); end
      n_cmp++; if (wq_b[1] !== 32'h0001_ABCD) begin n_bad++; $display("FAIL div_write1: got %h want 0001abcd", wq_b[1]); end
    end
    n_cmp++; if (first_lo_b !== HB) begin n_bad++; $display("FAIL div_cs_setup: got %0d want %0d", first_lo_b, HB); end
    n_cmp++; if ({hi_cnt_b, hi_bad_b} !== {24 + 16*NB, 32'd0}) begin
      n_bad++; $display("FAIL div_high: runs %0d bad %0d want %0d/0", hi_cnt_b, hi_bad_b, 24 + 16*NB); end
    n_cmp++; if ({lo3_b, lo4_b, lo_oth_b} !== {24 + 16*NB - (NB - 1), NB - 1, 32'd0}) begin
      n_bad++; $display("FAIL div_low: H %0d H+1 %0d other %0d want %0d/%0d/0", lo3_b, lo4_b, lo_oth_b, 24 + 16*NB - (NB - 1), NB - 1); end
    n_cmp++; if ({bad_b, mbad_b} !== 64'h0) begin n_bad++; $display("FAIL div_protocol: strobe errs %0d mosi errs %0d want 0", bad_b, mbad_b); end
    n_cmp++; if ({csn_b, booted_b, busy_b, addr_b} !== {3'b110, 16'(NB - 1)}) begin
      n_bad++; $display("FAIL div_done: got %b/%h want 110/%h", {csn_b, booted_b, busy_b}, addr_b, 16'(NB - 1)); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < 2*NA; i++) img_a[i] = 8'($urandom);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    wq_a.delete();
    rst_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin @(negedge clk); ok = (cnt_a >= 24 + 16 + 5); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL midrst_reach: word 1 data phase never reached"); end
    n_cmp++; if (wq_a.size() !== 1) begin n_bad++; $display("FAIL midrst_prewrites: got %0d want 1", wq_a.size()); end
    #2 rst_a = 1'b0;
    #1;
    n_cmp++; if ({csn_a, sck_a, busy_a, en_a} !== 4'b1000) begin
      n_bad++; $display("FAIL midrst_async: got %b want 1000", {csn_a, sck_a, busy_a, en_a}); end
    @(negedge clk);
    wq_a.delete();
    rst_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin @(negedge clk); ok = booted_a; end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL midrst_timeout: booted never rose after restart"); end
    n_cmp++; if (cmd_a !== 24'h030000) begin n_bad++; $display("FAIL midrst_cmd: got %h want 030000", cmd_a); end
    n_cmp++; if (wq_a.size() !== NA) begin n_bad++; $display("FAIL midrst_nwrites: got %0d want %0d", wq_a.size(), NA); end
    else begin
      n_cmp++; if (wq_a[0] !== {16'h0000, img_a[0], img_a[1]}) begin
        n_bad++; $display("FAIL midrst_word0: got %h want %h", wq_a[0], {16'h0000, img_a[0], img_a[1]}); end
    end
  endtask

  task automatic test_checksum();
    bit ok;
    logic [15:0] sum = 16'h0, w;
    img_b = '{8'h00, 8'h01, 8'hFF, 8'hFF};
    boot_b(ok);
    n_cmp++; if ({ok, booted_b, err_b} !== 3'b110) begin n_bad++; $display("FAIL ck_b_balanced: got %b want 110", {ok, booted_b, err_b}); end
    img_b = '{8'h00, 8'h01, 8'h00, 8'h01};
    boot_b(ok);
    n_cmp++; if ({ok, booted_b, err_b} !== {2'b11, CK_EN}) begin
      n_bad++; $display("FAIL ck_b_unbalanced: got %b want %b", {ok, booted_b, err_b}, {2'b11, CK_EN}); end
    repeat (20) @(negedge clk);
    n_cmp++; if (err_b !== CK_EN) begin n_bad++; $display("FAIL ck_b_sticky: got %b want %b", err_b, CK_EN); end
    for (int i = 0; i < NA - 1; i++) begin
      w = 16'($urandom);
      {img_a[2*i], img_a[2*i+1]} = w;
      sum = sum + w;
    end
    {img_a[2*NA-2], img_a[2*NA-1]} = 16'h0 - sum;
    boot_a(ok);
    n_cmp++; if ({ok, booted_a, err_a} !== 3'b110) begin n_bad++; $display("FAIL ck_a_balanced: got %b want 110", {ok, booted_a, err_a}); end
    {img_a[2*NA-2], img_a[2*NA-1]} = 16'h1 - sum;
    boot_a(ok);
    n_cmp++; if ({ok, booted_a, err_a} !== {2'b11, CK_EN}) begin
      n_bad++; $display("FAIL ck_a_unbalanced: got %b want %b", {ok, booted_a, err_a}, {2'b11, CK_EN}); end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    test_reset();
    test_framing(0);
    test_framing(1);
    test_framing(2);
    test_framing(0);
    test_divider();
    test_reset_mid();
    test_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_boot_loader.md
Name: spi_boot_loader

Overview:
- Boot-time copier inside UProc. After reset it streams the program image from the external SPI EEPROM (READ 0x03, mode 0) and writes it word-by-word into the parallel SRAM port.
- Asserts o_booted when finished; the state machine then drives the chip's isBooted pin.
- Owns the SPI pins and the SRAM address/enable/write pins until boot completes. Downstream muxing hands the SRAM pins to the core afterwards.

Parameters:
- NUM_WORDS, 32768: number of 16-bit words copied (EEPROM bytes = 2*NUM_WORDS); legal range 1..32768.
- HALF_PERIOD, 1: i_sysClk cycles per SPI clock half-period (>=1); SCK freq = sysClk/(2*HALF_PERIOD).

Ports:
- i_sysClk, input, 1: system clock; all logic on rising edge.
- i_sysRstn, input, 1: asynchronous active-low reset.
- i_spiMISO, input, 1: EEPROM serial data out.
- o_spiMOSI, output, 1: EEPROM serial data in.
- o_spiCLK, output, 1: SPI clock (mode 0, idle low).
- o_spiCSn, output, 1: EEPROM chip select, active low.
- o_memAddr, output, 16: SRAM word address being written.
- o_memData, output, 16: SRAM write data (drives io_memData via the core's tristate when o_memWr=1).
- o_memWr, output, 1: SRAM write request.
- o_memEn, output, 1: SRAM chip enable.
- o_busy, output, 1: high while copying.
- o_booted, output, 1: high (sticky) once all words are written.
- o_bootErr, output, 1: checksum failure (see Optional Feature).

Behaviour:
- Reset (async, any time): o_spiCSn=1, o_spiCLK=0, o_spiMOSI=0, o_memEn=0, o_memWr=0, o_memAddr=0, o_memData=0, o_busy=0, o_booted=0, o_bootErr=0; all counters cleared; FSM=IDLE. Reset mid-transfer aborts silently; on release the copy restarts from word 0.
- IDLE: one cycle after reset release -> SELECT; o_busy=1 from SELECT until DONE.
- SELECT: o_spiCSn=0 for HALF_PERIOD cycles with SCK low (CS setup) -> CMD.
- CMD: shift out 0x03, MSB first -> ADDR.
- ADDR: shift out 16-bit byte address 0x0000, MSB first -> DATA.
- SPI bit timing:
  - MOSI is valid before each SCK rise and changes only while SCK is low.
  - MISO is sampled in the cycle SCK rises.
  - Each bit takes 2*HALF_PERIOD cycles.
  - o_spiMOSI=0 during DATA.
- DATA: sample 16 bits, MSB first; first byte received = word[15:8] (big-endian) -> WRITE.
- WRITE: exactly one cycle, SCK held low, CSn stays low. In that cycle o_memEn=1, o_memWr=1, o_memAddr=word index, o_memData=assembled word.
  - Next cycle: o_memEn=0, o_memWr=0; index increments.
  - If index was NUM_WORDS-1 -> DONE, else -> DATA. The EEPROM auto-increments; no re-addressing.
- DONE: o_spiCSn=1, SCK=0, o_busy=0, o_booted=1, o_memEn=0. Terminal until reset. o_memAddr holds NUM_WORDS-1.
- Word index is 16 bits. NUM_WORDS=32768 ends at 0x7FFF with no wrap. NUM_WORDS=1 goes DATA->WRITE->DONE once.
- o_memEn and o_memWr are never high outside WRITE. o_memWr=1 implies o_memEn=1.
- All outputs are registered; no combinational path from i_spiMISO to any output.

Optional Feature:
- Macro: SPI_BOOT_CHECKSUM_EN.
- With the macro defined:
  - A 16-bit accumulator clears at reset and adds each written word (mod 2^16).
  - On entry to DONE, o_bootErr=1 iff the final sum != 0x0000. The image's last word is the two's-complement balancing word.
  - o_bootErr is sticky until reset.
  - o_booted still asserts regardless of the checksum result.
- Without the macro: no accumulator; o_bootErr tied 0.

Test Plan:
- Reset/idle: hold i_sysRstn=0 for 10 cycles -> CSn=1, SCK=0, memEn=0, booted=0, busy=0.
- Command/address framing: NUM_WORDS=2, HALF_PERIOD=1, EEPROM model bytes 12 34 AB CD.
  - MOSI sampled on SCK rises = 0x03 then 0x0000 (24 bits).
  - Writes observed: addr 0 data 0x1234, then addr 1 data 0xABCD.
  - Each write is a single cycle with memWr=memEn=1.
  - booted=1 and CSn=1 after the second write.
- Clock divider: HALF_PERIOD=3 -> SCK high and low each 3 cycles. No MOSI change while SCK is high. CSn low for 3 cycles before the first SCK rise.
- Reset mid-DATA of word 1 (NUM_WORDS=4) -> CSn=1 immediately (async). After release, the framing restarts with 0x03/0x0000 and word 0 is rewritten at addr 0.
- Checksum (macro on): image words 0x0001, 0xFFFF -> bootErr=0. Image 0x0001, 0x0001 -> bootErr=1 and booted=1.
- Checksum (macro off): the 0x0001, 0x0001 image -> bootErr stays 0.
